wave_capture_scheduler: RTL and testbench

WAVE_CAPTURE_SCHEDULER -- requirements
Module: wave_capture_scheduler

---
 rtl/wave_capture_scheduler_pkg.sv | 29 ++
 rtl/wave_capture_scheduler_sample_buffer.sv | 61 ++++++
 rtl/wave_capture_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_wave_capture_scheduler.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_capture_scheduler_pkg.sv
// Shared definitions for the waveform capture scheduler.
//   state_t     : FSM state encoding (legacy-compatible localparam constants)
//   ADDR_*      : plotter register map
//   trk_width() : width of a track index, never below one bit
package wave_capture_scheduler_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_CFG       = 3'd1;
  localparam state_t ST_CFG_WAIT  = 3'd2;
  localparam state_t ST_CAPTURE   = 3'd3;
  localparam state_t ST_SEL       = 3'd4;
  localparam state_t ST_SEL_WAIT  = 3'd5;
  localparam state_t ST_DATA      = 3'd6;
  localparam state_t ST_DATA_WAIT = 3'd7;

  localparam logic [3:0] ADDR_DATA = 4'd0;
  localparam logic [3:0] ADDR_SPI  = 4'd1;
  localparam logic [3:0] ADDR_CFG  = 4'd2;
  localparam logic [3:0] ADDR_SEL  = 4'd8;

  localparam int SAMPLES_PER_BYTE = 8;

  function automatic int trk_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wave_capture_scheduler_sample_buffer.sv
// wave_sample_buffer: sample-interval divider, sample counter and one 8-bit
// shift register per probe track.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   clear        : load divider from div, clear sample count (frame start)
//   enable       : capture phase active; divider counts down
//   div          : sample interval minus 1
//   probe_in     : one bit per track
//   shreg        : captured bytes, first sample ends in bit 7
//   sample_done  : single-cycle pulse on the edge that takes the 8th sample
module wave_sample_buffer
  import wave_capture_scheduler_pkg::*;
#(
  parameter int NUM_TRACKS = 4,
  parameter int DIV_W      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       enable,
  input  logic [DIV_W-1:0]           div,
  input  logic [NUM_TRACKS-1:0]      probe_in,
  output logic [NUM_TRACKS-1:0][7:0] shreg,
  output logic                       sample_done
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       sample_cnt;
  logic             tick;

  // Terminal count of the down-counter marks a sample edge.
  assign tick        = enable && (div_cnt == '0);
  assign sample_done = tick && (sample_cnt == 4'(SAMPLES_PER_BYTE - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q      <= '0;
      div_cnt    <= '0;
      sample_cnt <= '0;
      shreg      <= '0;
    end else if (clear) begin
      // Interval is frozen for the whole frame so a div change cannot
      // stretch or wrap the divider mid-capture.
      div_q      <= div;
      div_cnt    <= div;
      sample_cnt <= '0;
    end else if (enable) begin
      if (tick) begin
        div_cnt    <= div_q;
        sample_cnt <= sample_cnt + 4'd1;
        for (int t = 0; t < NUM_TRACKS; t++) begin
          shreg[t] <= {shreg[t][6:0], probe_in[t]};
        end
      end else begin
        div_cnt <= div_cnt - DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/wave_capture_scheduler.sv
// Captures 8 samples of every probe track, then writes the resulting bytes to
// an OLED plotter, one page per track.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   probe_in      : probe bits, already in the clk domain
//   start         : single-cycle frame request (only honoured in IDLE)
//   continuous    : restart automatically after each frame
//   div           : sample interval minus 1
//   cfg           : byte written to the plotter config register each frame
//   busy          : frame in progress
//   plot_address  : plotter register address (holds last written value)
//   plot_write    : single-cycle write strobe
//   plot_data     : plotter write data (holds last written value)
//   plot_idle     : plotter ready
//
// state      | meaning
// IDLE       | waiting for start
// CFG        | write cfg to ADDR_CFG once plotter idle
// CFG_WAIT   | one dead cycle, then wait for plotter idle
// CAPTURE    | divider running, 8 samples per track
// SEL        | write track index to ADDR_SEL once plotter idle
// SEL_WAIT   | one dead cycle, then wait for plotter idle
// DATA       | write captured byte to ADDR_DATA once plotter idle
// DATA_WAIT  | one dead cycle, then wait; next track or frame end
module wave_capture_scheduler
  import wave_capture_scheduler_pkg::*;
#(
  parameter int NUM_TRACKS = 4,
  parameter int DIV_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_TRACKS-1:0] probe_in,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [DIV_W-1:0]      div,
  input  logic [7:0]            cfg,
  output logic                  busy,
  output logic [3:0]            plot_address,
  output logic                  plot_write,
  output logic [7:0]            plot_data,
  input  logic                  plot_idle
);

  localparam int               TRK_W    = trk_width(NUM_TRACKS);
  localparam logic [TRK_W-1:0] LAST_TRK = TRK_W'(NUM_TRACKS - 1);

  state_t                       state, state_nxt;
  logic [TRK_W-1:0]             track, track_nxt;
  logic                         wait_first, wait_first_nxt;
  logic [3:0]                   addr_q;
  logic [7:0]                   data_q;
  logic                         wr_req;
  logic [3:0]                   wr_addr;
  logic [7:0]                   wr_data;
  logic [2:0]                   trk3;
  logic                         buf_clear;
  logic                         buf_enable;
  logic                         sample_done;
  logic [NUM_TRACKS-1:0][7:0]   shreg;

  wave_sample_buffer #(
    .NUM_TRACKS (NUM_TRACKS),
    .DIV_W      (DIV_W)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (buf_clear),
    .enable      (buf_enable),
    .div         (div),
    .probe_in    (probe_in),
    .shreg       (shreg),
    .sample_done (sample_done)
  );

  assign trk3       = 3'(track);
  assign buf_enable = (state == ST_CAPTURE);
  assign busy       = (state != ST_IDLE);

  // Write strobe is combinational on plot_idle so it can only ever fire in a
  // cycle where the plotter reports idle; the FSM leaves the write state on
  // the same edge, which keeps strobes at least two cycles apart.
  always_comb begin
    wr_req  = 1'b0;
    wr_addr = addr_q;
    wr_data = data_q;
    case (state)
      ST_CFG: begin
        wr_req  = plot_idle;
        wr_addr = ADDR_CFG;
        wr_data = cfg;
      end
      ST_SEL: begin
        wr_req  = plot_idle;
        wr_addr = ADDR_SEL;
        wr_data = {5'b0, trk3};
      end
      ST_DATA: begin
        wr_req  = plot_idle;
        wr_addr = ADDR_DATA;
        wr_data = shreg[track];
      end
      default: ;
    endcase
  end

  // Gating with rst_n suppresses a write in the very cycle reset is applied.
  assign plot_write   = rst_n && wr_req;
  assign plot_address = plot_write ? wr_addr : addr_q;
  assign plot_data    = plot_write ? wr_data : data_q;

  always_comb begin
    state_nxt      = state;
    track_nxt      = track;
    wait_first_nxt = 1'b0;
    buf_clear      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CFG;
      end
      ST_CFG: begin
        if (plot_idle) begin
          state_nxt      = ST_CFG_WAIT;
          wait_first_nxt = 1'b1;
        end
      end
      ST_CFG_WAIT: begin
        if (!wait_first && plot_idle) begin
          state_nxt = ST_CAPTURE;
          buf_clear = 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (sample_done) begin
          state_nxt = ST_SEL;
          track_nxt = '0;
        end
      end
      ST_SEL: begin
        if (plot_idle) begin
          state_nxt      = ST_SEL_WAIT;
          wait_first_nxt = 1'b1;
        end
      end
      ST_SEL_WAIT: begin
        if (!wait_first && plot_idle) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (plot_idle) begin
          state_nxt      = ST_DATA_WAIT;
          wait_first_nxt = 1'b1;
        end
      end
      ST_DATA_WAIT: begin
        if (!wait_first && plot_idle) begin
          if (track == LAST_TRK) begin
            state_nxt = continuous ? ST_CFG : ST_IDLE;
          end else begin
            track_nxt = track + TRK_W'(1);
            state_nxt = ST_SEL;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      track      <= '0;
      wait_first <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      state      <= state_nxt;
      track      <= track_nxt;
      wait_first <= wait_first_nxt;
      if (wr_req) begin
        addr_q <= wr_addr;
        data_q <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_wave_capture_scheduler.sv
// Directed bench for wave_capture_scheduler with a plotter model that drops
// plot_idle for 20 cycles after every SEL/DATA write.
module tb_wave_capture_scheduler;
  import wave_capture_scheduler_pkg::*;

  localparam int NT = 4;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic [DW-1:0] div = '0;
  logic [7:0]    cfg = 8'h5A;
  logic [NT-1:0] probe_in;
  logic [NT-1:0] probe_static = '0;
  logic [NT-1:1] probe_hi = '0;
  logic          toggle_mode = 1'b0;
  logic [31:0]   cap_phase = '0;
  int            cap_cnt = 0;
  int            cap_len = 0;
  logic          busy, plot_write, plot_idle;
  logic [3:0]    plot_address;
  logic [7:0]    plot_data;
  int            idle_cnt = 0;
  logic          force_busy = 1'b0;
  logic [11:0]   wr_log[$];
  logic          prev_write = 1'b0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  assign probe_in  = toggle_mode ? {probe_hi, ~cap_phase[2]} : probe_static;
  assign plot_idle = (idle_cnt == 0) && !force_busy;

  wave_capture_scheduler #(.NUM_TRACKS(NT), .DIV_W(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .probe_in     (probe_in),
    .start        (start),
    .continuous   (continuous),
    .div          (div),
    .cfg          (cfg),
    .busy         (busy),
    .plot_address (plot_address),
    .plot_write   (plot_write),
    .plot_data    (plot_data),
    .plot_idle    (plot_idle)
  );

  always @(posedge clk) begin
    if (plot_write && plot_address != ADDR_CFG) idle_cnt <= 20;
    else if (idle_cnt > 0) idle_cnt <= idle_cnt - 1;
  end

  // Probe toggler: phase counts cycles from capture entry, probe[0] = 1 for
  // the first 4 cycles, 0 for the next 4, ...
  always @(negedge clk) begin
    if (dut.state == ST_CAPTURE) begin
      cap_phase = 32'(cap_cnt);
      cap_cnt   = cap_cnt + 1;
      cap_len   = cap_len + 1;
    end else begin
      cap_cnt = 0;
    end
  end

  // Write logger and write-strobe protocol monitor.
  always @(negedge clk) begin
    if (plot_write) begin
      wr_log.push_back({plot_address, plot_data});
      checks++;
      if (prev_write) begin
        errors++;
        $display("FAIL write_spacing: plot_write high in consecutive cycles at %0t", $time);
      end
      if (!plot_idle) begin
        errors++;
        $display("FAIL write_while_busy: plot_write=1 with plot_idle=0 at %0t", $time);
      end
      if (!(dut.state inside {ST_CFG, ST_SEL, ST_DATA})) begin
        errors++;
        $display("FAIL write_state: write in state %0d at %0t", dut.state, $time);
      end
    end
    prev_write = plot_write;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got busy=%0b want end of tests", busy);
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit timed_out);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    timed_out = busy;
  endtask

  task automatic wait_state(input state_t st, input int trk, input int limit, output bit timed_out);
    int n = 0;
    while (!(dut.state == st && (trk < 0 || int'(dut.track) == trk)) && n < limit) begin
      @(negedge clk);
      n++;
    end
    timed_out = !(dut.state == st && (trk < 0 || int'(dut.track) == trk));
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || plot_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy=%b plot_write=%b, want 0 0", busy, plot_write);
    end
    checks++;
    if (plot_address !== 4'h0 || plot_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus: addr=%h data=%h, want 0 00", plot_address, plot_data);
    end
    checks++;
    if (dut.state !== ST_IDLE || dut.shreg !== '0) begin
      errors++;
      $display("FAIL reset_state: state=%0d shreg=%h, want 0 0", dut.state, dut.shreg);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [11:0] exp [9];
    logic [11:0] got;
    bit to;
    exp = '{12'h25A, 12'h800, 12'h0FF, 12'h801, 12'h000, 12'h802, 12'h0FF, 12'h803, 12'h000};
    cfg = 8'h5A; div = '0; toggle_mode = 1'b0; probe_static = 4'b0101;
    wr_log.delete();
    pulse_start();
    wait_state(ST_SEL, -1, 500, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL basic_reach_sel: state=%0d, want %0d", dut.state, ST_SEL);
    end
    probe_static = 4'b1010;  // must not disturb the captured bytes
    wait_idle(2000, to);
    checks++;
    if (to || wr_log.size() != 9) begin
      errors++;
      $display("FAIL basic_count: writes=%0d timeout=%0b, want 9 0", wr_log.size(), to);
    end
    for (int i = 0; i < 9; i++) begin
      got = (i < wr_log.size()) ? wr_log[i] : 12'hxxx;
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL basic_write%0d: got %h, want %h", i, got, exp[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || plot_address !== 4'h0 || plot_data !== 8'h00) begin
      errors++;
      $display("FAIL basic_hold: busy=%b addr=%h data=%h, want 0 0 00", busy, plot_address, plot_data);
    end
  endtask

  task automatic test_div3();
    logic [11:0] exp [9];
    logic [11:0] got;
    bit to;
    exp = '{12'h2C3, 12'h800, 12'h0AA, 12'h801, 12'h0FF, 12'h802, 12'h0FF, 12'h803, 12'h000};
    cfg = 8'hC3; div = 16'd3; toggle_mode = 1'b1; probe_hi = 3'b011;
    wr_log.delete();
    cap_len = 0;
    pulse_start();
    wait_idle(3000, to);
    checks++;
    if (to || wr_log.size() != 9) begin
      errors++;
      $display("FAIL div3_count: writes=%0d timeout=%0b, want 9 0", wr_log.size(), to);
    end
    checks++;
    if (cap_len != 32) begin
      errors++;
      $display("FAIL div3_capture_len: got %0d cycles, want 32", cap_len);
    end
    for (int i = 0; i < 9; i++) begin
      got = (i < wr_log.size()) ? wr_log[i] : 12'hxxx;
      checks++;
      if (got !== exp[i]) begin
        errors++;
        $display("FAIL div3_write%0d: got %h, want %h", i, got, exp[i]);
      end
    end
    toggle_mode = 1'b0;
  endtask

  task automatic test_start_ignored();
    bit to;
    cfg = 8'h11; div = 16'd1; probe_static = 4'b0011;
    wr_log.delete();
    pulse_start();
    wait_state(ST_DATA_WAIT, -1, 1000, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL ign_reach_data_wait: state=%0d, want %0d", dut.state, ST_DATA_WAIT);
    end
    pulse_start();
    wait_idle(2000, to);
    repeat (30) @(negedge clk);
    checks++;
    if (to || wr_log.size() != 9 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ign_count: writes=%0d busy=%b timeout=%0b, want 9 0 0", wr_log.size(), busy, to);
    end
    checks++;
    if (wr_log.size() < 9 || wr_log[2] !== 12'h0FF || wr_log[8] !== 12'h000) begin
      errors++;
      $display("FAIL ign_data: size=%0d, want bytes FF (trk0) and 00 (trk3)", wr_log.size());
    end
  endtask

  task automatic test_continuous();
    bit to;
    int n = 0;
    cfg = 8'h77; div = '0; probe_static = 4'b1111; continuous = 1'b1;
    wr_log.delete();
    pulse_start();
    while (wr_log.size() < 10 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wr_log.size() < 10 || wr_log[9] !== 12'h277 || busy !== 1'b1) begin
      errors++;
      $display("FAIL cont_second_cfg: writes=%0d busy=%b, want >=10 with write9=277 busy=1", wr_log.size(), busy);
    end
    continuous = 1'b0;
    wait_idle(3000, to);
    repeat (30) @(negedge clk);
    checks++;
    if (to || wr_log.size() != 18 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cont_total: writes=%0d busy=%b timeout=%0b, want 18 0 0", wr_log.size(), busy, to);
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    cfg = 8'h42; div = '0; probe_static = 4'b0110;
    wr_log.delete();
    pulse_start();
    wait_state(ST_SEL_WAIT, 2, 2000, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL rstmid_reach: state=%0d track=%0d, want SEL_WAIT track 2", dut.state, dut.track);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (dut.state !== ST_IDLE || busy !== 1'b0 || plot_write !== 1'b0 ||
        plot_address !== 4'h0 || plot_data !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_outputs: state=%0d busy=%b wr=%b addr=%h data=%h, want 0 0 0 0 00",
               dut.state, busy, plot_write, plot_address, plot_data);
    end
    checks++;
    if (wr_log.size() != 6) begin
      errors++;
      $display("FAIL rstmid_before: writes=%0d, want 6", wr_log.size());
    end
    repeat (200) @(negedge clk);
    checks++;
    if (wr_log.size() != 6 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: writes=%0d busy=%b, want 6 0", wr_log.size(), busy);
    end
  endtask

  task automatic test_stall();
    bit to;
    cfg = 8'h9C; div = 16'd2; probe_static = 4'b1001;
    wr_log.delete();
    force_busy = 1'b1;
    pulse_start();
    repeat (100) @(negedge clk);
    checks++;
    if (wr_log.size() != 0 || dut.state !== ST_CFG) begin
      errors++;
      $display("FAIL stall_hold: writes=%0d state=%0d, want 0 %0d", wr_log.size(), dut.state, ST_CFG);
    end
    force_busy = 1'b0;
    wait_idle(3000, to);
    checks++;
    if (to || wr_log.size() != 9 || wr_log[0] !== 12'h29C) begin
      errors++;
      $display("FAIL stall_release: writes=%0d timeout=%0b, want 9 writes starting 29C", wr_log.size(), to);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div3();
    test_start_ignored();
    test_continuous();
    test_reset_mid();
    test_stall();
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
